lut_config_loader: RTL and testbench
====================================

# lut_config_loader

Configuration writer for the LUT fabric: it accepts a byte-wide configuration stream through a valid/ready handshake and frames it as sync byte, mask bytes, then checksum. It stages the mask bytes in shadow registers and commits them atomically to the 8-bit truth-table masks of `NUM_LUTS` three-input LUTs. The block sits between the configuration port and the LUT array; the LUTs only ever see a complete, checksum-verified mask set.

## Interface
Parameters:
- `NUM_LUTS`, 4, number of 3-input LUTs configured; ≥1
- `SYNC_BYTE`, 8'hA5, frame-start marker

Ports:
- `clk`  in  1  clock; all state changes on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin a configuration frame; sampled only in IDLE
- `in_valid`  in  1  `in_data` holds a byte
- `in_data`  in  8  configuration byte
- `in_ready`  out  1  loader accepts a byte this cycle
- `mask_out`  out  `NUM_LUTS*8`  committed masks. Bit `8*k+i` is the output of LUT k for input index i = 4a+2b+c.
- `busy`  out  1  frame in progress (state ≠ IDLE)
- `done`  out  1  one-cycle pulse: frame committed
- `error`  out  1  one-cycle pulse: checksum mismatch, frame discarded

## Operation
- Transfer: a byte is consumed on a rising edge where `in_valid & in_ready`. No other edge consumes data. `in_data` is ignored otherwise.
- States:
  - IDLE: `in_ready`=0. `start`=1 → WAIT_SYNC. The frame index and running checksum clear to 0.
  - WAIT_SYNC: `in_ready`=1. Byte == `SYNC_BYTE` → LOAD. Any other byte is discarded and the state stays WAIT_SYNC.
  - LOAD: `in_ready`=1. Each byte is written to `shadow[idx]`, XORed into the checksum, and `idx` increments. When the byte at `idx == NUM_LUTS-1` is consumed → CHECK.
  - CHECK: `in_ready`=1. One byte is consumed.
    - If it equals the running XOR (seed 8'h00) of all mask bytes: every shadow byte copies into `mask_out` on that edge, `done` pulses, and the state goes to IDLE.
    - Otherwise: `mask_out` is unchanged, `error` pulses, and the state goes to IDLE.
- A sync-valued byte inside LOAD or CHECK is treated as data. There is no resynchronisation.
- `start` outside IDLE is ignored.
- `mask_out` never shows a partial frame. The previous configuration is held throughout a frame and after an error.
- Width rules:
  - `idx` is `$clog2(NUM_LUTS)` bits, minimum 1.
  - The checksum is 8-bit XOR with no carry.
  - Byte k maps to `mask_out[8*k +: 8]`, with bit i of the byte going to LUT input index i.

## Timing
- Reset values (asynchronous, on `rst_n`=0):
  - state IDLE
  - `in_ready`=0, `busy`=0, `done`=0, `error`=0
  - `mask_out`=0, shadow=0, `idx`=0, checksum=0
- Reset mid-frame aborts immediately. `mask_out` returns to 0, not to the previous configuration.
- All outputs are registered or decoded from state, with no combinational path from `in_valid`/`in_data`:
  - `in_ready` = state ∈ {WAIT_SYNC, LOAD, CHECK}
  - `busy` = state ≠ IDLE
- `start` accepted at edge N: `in_ready`=1 from cycle N+1.
- Minimum frame length is `NUM_LUTS`+2 transfers. At full throughput the frame completes `NUM_LUTS`+2 cycles after the first `in_ready`.
- On the checksum edge M:
  - `mask_out` is new, and `done` or `error` is high, for cycle M+1 only.
  - `busy`=0 and `in_ready`=0 in cycle M+1.
  - A new `start` is accepted at edge M+1.
- `in_valid` deasserted mid-frame stalls indefinitely. There is no timeout, and state and index are held.
- `done` and `error` are never both high. Neither is high outside the cycle after the checksum edge.

## Test plan
- Reset: assert `rst_n`=0 mid-LOAD after 2 bytes → `mask_out`=0, `busy`=0, `in_ready`=0 immediately without a clock. After release, the loader sits in IDLE.
- Good frame (`NUM_LUTS`=4), stream A5, 96, E8, 80, FE, 00 with `in_valid` held high → `mask_out`=32'hFE80E896, `done` one cycle, `error`=0.
  - LUT0 behaves as XOR3, LUT1 as majority, LUT2 as AND3, LUT3 as OR3.
- Bad checksum: committed FE80E896, then stream A5, 11, 22, 33, 44, 01 (expected 44) → `error` one cycle, `done`=0, `mask_out` stays FE80E896.
- Sync hunt and backpressure:
  - After `start`, send 00, 5A, then A5, then the good frame with `in_valid` toggled every other cycle → the leading 00 and 5A are discarded and the same result as the good frame is reached.
  - Every byte consumed is counted exactly once.
- Ignored start: pulse `start` during LOAD → no restart. The frame completes normally.
- Back-to-back: `start` at the cycle `done` is high, followed by a second valid frame → second commit is correct and `mask_out` updates only on its checksum edge.

Source files
------------

// File: rtl/lut_config_loader.sv
// Frames a byte stream (sync, NUM_LUTS mask bytes, XOR checksum) into shadow
// registers and commits the whole mask set to the LUT array only when the checksum matches.
module lut_config_loader #(
   parameter int          NUM_LUTS  = 4,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   output logic [NUM_LUTS*8-1:0] mask_out,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam int                IDX_W    = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_LUTS - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT_SYNC, ST_LOAD, ST_CHECK} state_t;

   state_t                state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [7:0]            csum_q, csum_d;
   logic [NUM_LUTS*8-1:0] shadow_q, shadow_d;
   logic [NUM_LUTS*8-1:0] mask_q, mask_d;
   logic                  in_ready_q, in_ready_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;
   logic                  xfer;

   // Handshake: a byte moves only on a rising edge with in_valid & in_ready both high;
   // in_ready is a registered state decode, so it never depends on in_valid or in_data.
   assign xfer = in_valid & in_ready_q;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      csum_d   = csum_q;
      shadow_d = shadow_q;
      mask_d   = mask_q;
      done_d   = 1'b0;
      error_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_WAIT_SYNC;
               idx_d   = '0;
               csum_d  = 8'h00;
            end
         end
         ST_WAIT_SYNC: begin
            if (xfer && (in_data == SYNC_BYTE)) begin
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (xfer) begin
               for (int k = 0; k < NUM_LUTS; k++) begin
                  if (idx_q == IDX_W'(k)) begin
                     shadow_d[8*k +: 8] = in_data;
                  end
               end
               csum_d = csum_q ^ in_data;
               if (idx_q == LAST_IDX) begin
                  state_d = ST_CHECK;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         ST_CHECK: begin
            if (xfer) begin
               // The commit is all-or-nothing: the LUTs never see a partial set.
               if (in_data == csum_q) begin
                  mask_d = shadow_q;
                  done_d = 1'b1;
               end else begin
                  error_d = 1'b1;
               end
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      in_ready_d = (state_d != ST_IDLE);
      busy_d     = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         csum_q     <= 8'h00;
         shadow_q   <= '0;
         mask_q     <= '0;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         csum_q     <= csum_d;
         shadow_q   <= shadow_d;
         mask_q     <= mask_d;
         in_ready_q <= in_ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
      end
   end

   assign in_ready = in_ready_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign error    = error_q;
   assign mask_out = mask_q;

endmodule

// File: tb/tb_lut_config_loader.sv
// Directed bench for lut_config_loader: good/bad frames, reset abort, sync hunt with
// backpressure, ignored start and back-to-back frames, with a commit scoreboard.
module tb_lut_config_loader;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic [31:0] mask_out;
   logic        busy;
   logic        done;
   logic        error;

   int          n_checks = 0;
   int          n_errors = 0;
   int          sent = 0;
   int          consumed = 0;
   logic [31:0] exp_q[$];
   logic [31:0] cur_mask = 32'h0;
   logic [7:0]  frame_q[$];
   logic        prev_pulse = 1'b0;

   lut_config_loader #(.NUM_LUTS(4), .SYNC_BYTE(8'hA5)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .mask_out (mask_out),
      .busy     (busy),
      .done     (done),
      .error    (error)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // transfer monitor: registered outputs read here still hold their pre-edge values
   always @(posedge clk) begin
      if (rst_n && in_valid && in_ready) consumed++;
   end

   // scoreboard: every done pops one expected commit
   always @(negedge clk) begin
      if (rst_n && (done || error)) begin
         check_val("done_error_excl", {31'b0, done & error}, 32'h0);
         check_val("pulse_len", {31'b0, prev_pulse}, 32'h0);
      end
      if (rst_n && done) begin
         check_val("sb_pending", {31'b0, exp_q.size() != 0}, 32'h1);
         if (exp_q.size() != 0) begin
            cur_mask = exp_q.pop_front();
            check_val("sb_commit", mask_out, cur_mask);
         end
      end
      prev_pulse = done | error;
   end

   // drivers (called and returning on a falling edge)
   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check_val("ready_wait", {31'b0, in_ready}, 32'h1);
      @(negedge clk);
      sent++;
      in_valid = 1'b0;
      in_data  = 8'hA5;
      repeat (gap) @(negedge clk);
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_val("ready_after_start", {31'b0, in_ready}, 32'h1);
      check_val("busy_after_start", {31'b0, busy}, 32'h1);
   endtask

   task automatic send_frame(input int gap, input int ign_pos, input logic ok, input logic [31:0] exp);
      int len;
      len = frame_q.size();
      if (ok) exp_q.push_back(exp);
      for (int i = 0; i < len; i++) begin
         if (i == len - 1) check_val("mask_hold", mask_out, cur_mask);
         if (i == ign_pos) start = 1'b1;
         send_byte(frame_q[i], (i == len - 1) ? 0 : gap);
         start = 1'b0;
      end
      check_val("done_pulse", {31'b0, done}, {31'b0, ok});
      check_val("error_pulse", {31'b0, error}, {31'b0, !ok});
      check_val("busy_end", {31'b0, busy}, 32'h0);
      check_val("ready_end", {31'b0, in_ready}, 32'h0);
      check_val("mask_end", mask_out, ok ? exp : cur_mask);
   endtask

   task automatic check_luts();
      logic [7:0] e [4];
      logic a, b, c;
      for (int i = 0; i < 8; i++) begin
         a = i[2];
         b = i[1];
         c = i[0];
         e[0][i] = a ^ b ^ c;
         e[1][i] = (a & b) | (a & c) | (b & c);
         e[2][i] = a & b & c;
         e[3][i] = a | b | c;
      end
      for (int k = 0; k < 4; k++) begin
         check_val($sformatf("lut%0d_func", k), {24'b0, mask_out[8*k +: 8]}, {24'b0, e[k]});
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (2) @(negedge clk);
      check_val("rst_mask", mask_out, 32'h0);
      check_val("rst_busy", {31'b0, busy}, 32'h0);
      check_val("rst_ready", {31'b0, in_ready}, 32'h0);
      check_val("rst_done_err", {30'b0, done, error}, 32'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_val("idle_ready", {31'b0, in_ready}, 32'h0);

      // good frame at full throughput
      do_start();
      frame_q = '{8'hA5, 8'h96, 8'hE8, 8'h80, 8'hFE, 8'h00};
      send_frame(0, -1, 1'b1, 32'hFE80E896);
      check_luts();
      @(negedge clk);
      check_val("done_one_cycle", {31'b0, done}, 32'h0);

      // bad checksum: expected 44, sent 01
      do_start();
      frame_q = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h01};
      send_frame(0, -1, 1'b0, 32'h0);
      @(negedge clk);
      check_val("error_one_cycle", {31'b0, error}, 32'h0);
      check_val("mask_after_err", mask_out, 32'hFE80E896);

      // reset mid-LOAD after two mask bytes aborts without a clock edge
      do_start();
      send_byte(8'hA5, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      #2 rst_n = 1'b0;
      #1;
      check_val("midrst_mask", mask_out, 32'h0);
      check_val("midrst_busy", {31'b0, busy}, 32'h0);
      check_val("midrst_ready", {31'b0, in_ready}, 32'h0);
      cur_mask = 32'h0;
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_val("post_rst_busy", {31'b0, busy}, 32'h0);
      check_val("post_rst_ready", {31'b0, in_ready}, 32'h0);

      // start pulsed during LOAD is ignored
      do_start();
      frame_q = '{8'hA5, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0F};
      send_frame(0, 2, 1'b1, 32'h08040201);
      @(negedge clk);

      // sync hunt with in_valid toggled every other cycle
      do_start();
      frame_q = '{8'h00, 8'h5A, 8'hA5, 8'h96, 8'hE8, 8'h80, 8'hFE, 8'h00};
      send_frame(1, -1, 1'b1, 32'hFE80E896);

      // back-to-back: start while done is high
      do_start();
      frame_q = '{8'hA5, 8'h10, 8'h20, 8'h40, 8'h80, 8'hF0};
      send_frame(0, -1, 1'b1, 32'h80402010);
      repeat (2) @(negedge clk);

      check_val("byte_count", consumed, sent);
      check_val("sb_drained", exp_q.size(), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
